// File: rtl/keypad_pkg.sv
// Shared state encoding, key codes and digit-range constants for the keypad code lock.
// Definitions only: no logic, no latency, no flow control.
package keypad_pkg;

   // One-hot so each status output is a direct decode of a single state bit.
   typedef enum logic [3:0] {
      ST_ENTRY    = 4'b0001,
      ST_UNLOCKED = 4'b0010,
      ST_ERROR    = 4'b0100,
      ST_LOCKOUT  = 4'b1000
   } lock_state_t;

   localparam logic [3:0] KEY_ENTER  = 4'hF;
   localparam logic [3:0] DIGIT_MIN  = 4'd0;
   localparam logic [3:0] DIGIT_MAX  = 4'd9;
   localparam logic [2:0] MAX_DIGITS = 3'd4;

   // Unsigned wrap lets one compare cover both ends of the digit range.
   function automatic logic is_digit(input logic [3:0] key);
      return (key - DIGIT_MIN) <= (DIGIT_MAX - DIGIT_MIN);
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Key debouncer: accept is combinational and marks the edge completing a stable-high run.
// Latency DEBOUNCE_CYCLES; no backpressure, re-arms only after a stable-low run of equal length.
module keypad_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic dav,
   output logic accept
);

   localparam logic [15:0] LAST = DEBOUNCE_CYCLES - 16'd1;

   logic        armed;
   logic [15:0] run;
   logic        run_done;

   assign run_done = (run == LAST);
   assign accept   = armed && dav && run_done;

   // When armed we time a high run (to accept); when disarmed we time a low run (to re-arm).
   // Any sample in the other direction restarts the run, so short glitches never count.
   always_ff @(posedge clk) begin
      if (reset) begin
         armed <= 1'b0;
         run   <= '0;
      end else if (armed == dav) begin
         if (run_done) begin
            armed <= ~armed;
            run   <= '0;
         end else begin
            run   <= run + 16'd1;
         end
      end else begin
         run <= '0;
      end
   end

endmodule

// File: rtl/keypad_code_lock.sv
// Four-digit keypad code lock with fail counting, timed unlock/error hold and lockout.
// Status changes one cycle after key acceptance; no backpressure, keys outside ENTRY are dropped.
module keypad_code_lock
   import keypad_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [15:0] CODE            = 16'h1234,
   parameter logic [31:0] HOLD_CYCLES     = 32'd50_000_000,
   parameter logic [31:0] LOCKOUT_CYCLES  = 32'd500_000_000,
   parameter int          MAX_FAILS       = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  d,
   input  logic        dav,
   output logic [15:0] digits,
   output logic [2:0]  count,
   output logic        key_valid,
   output logic        unlocked,
   output logic        error,
   output logic        locked_out
);

   localparam int FW = $clog2(MAX_FAILS + 1);

   lock_state_t   state_q, state_d;
   logic [15:0]   digits_q, digits_d;
   logic [2:0]    count_q, count_d;
   logic [FW-1:0] fail_q, fail_d, fail_inc;
   logic [31:0]   dwell_q, dwell_d;
   logic          accept;

   keypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .dav    (dav),
      .accept (accept)
   );

   assign fail_inc = fail_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_ENTRY;
         digits_q  <= '0;
         count_q   <= '0;
         fail_q    <= '0;
         dwell_q   <= '0;
         key_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         count_q   <= count_d;
         fail_q    <= fail_d;
         dwell_q   <= dwell_d;
         key_valid <= accept;
      end
   end

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      count_d  = count_q;
      fail_d   = fail_q;
      dwell_d  = dwell_q;
      case (state_q)
         ST_ENTRY: begin
            dwell_d = '0;
            // Unknown or A-E keys fall through both tests and leave everything unchanged.
            if (accept) begin
               if (is_digit(d)) begin
                  if (count_q < MAX_DIGITS) begin
                     digits_d = {digits_q[11:0], d};
                     count_d  = count_q + 3'd1;
                  end
               end else if (d == KEY_ENTER) begin
                  digits_d = '0;
                  count_d  = '0;
                  if ((count_q == MAX_DIGITS) && (digits_q == CODE)) begin
                     state_d = ST_UNLOCKED;
                     fail_d  = '0;
                  end else begin
                     fail_d  = fail_inc;
                     state_d = (fail_inc == FW'(MAX_FAILS)) ? ST_LOCKOUT : ST_ERROR;
                  end
               end
            end
         end
         ST_UNLOCKED, ST_ERROR: begin
            if (dwell_q == HOLD_CYCLES - 32'd1) begin
               state_d = ST_ENTRY;
               dwell_d = '0;
            end else begin
               dwell_d = dwell_q + 32'd1;
            end
         end
         ST_LOCKOUT: begin
            if (dwell_q == LOCKOUT_CYCLES - 32'd1) begin
               state_d = ST_ENTRY;
               dwell_d = '0;
               fail_d  = '0;
            end else begin
               dwell_d = dwell_q + 32'd1;
            end
         end
         default: begin
            state_d  = ST_ENTRY;
            digits_d = '0;
            count_d  = '0;
            dwell_d  = '0;
         end
      endcase
   end

   always_comb begin
      digits     = digits_q;
      count      = count_q;
      unlocked   = (state_q == ST_UNLOCKED);
      error      = (state_q == ST_ERROR);
      locked_out = (state_q == ST_LOCKOUT);
   end

endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: directed scenarios plus randomized key presses against a key-level model.
// The model works from press/release run lengths and a digit queue, sampled 1ns after each edge.
module tb_keypad_code_lock;

   localparam logic [15:0] DEB    = 16'd4;
   localparam logic [15:0] CODE_P = 16'h1234;
   localparam logic [31:0] HOLD   = 32'd8;
   localparam logic [31:0] LOCK   = 32'd16;
   localparam int          MAXF   = 3;
   localparam logic [3:0]  KEY_F  = 4'hF;
   localparam int M_ENTRY = 0, M_UNL = 1, M_ERR = 2, M_LOCK = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dav = 1'b0;
   logic [3:0]  d = 4'h0;
   logic [15:0] digits;
   logic [2:0]  count;
   logic        key_valid, unlocked, error, locked_out;
   logic [22:0] obs;

   int checks = 0, errors = 0;
   int m_q[$];
   int m_fails = 0, m_mode = M_ENTRY, m_left = 0;
   bit m_kv = 1'b0;
   int hi_run = 0, lo_run = 0;
   bit rearmed = 1'b0;
   int kv_seen = 0, unl_seen = 0, err_seen = 0, lock_seen = 0;

   keypad_code_lock #(
      .DEBOUNCE_CYCLES(DEB),
      .CODE           (CODE_P),
      .HOLD_CYCLES    (HOLD),
      .LOCKOUT_CYCLES (LOCK),
      .MAX_FAILS      (MAXF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .d          (d),
      .dav        (dav),
      .digits     (digits),
      .count      (count),
      .key_valid  (key_valid),
      .unlocked   (unlocked),
      .error      (error),
      .locked_out (locked_out)
   );

   assign obs = {digits, count, key_valid, unlocked, error, locked_out};

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid)  kv_seen++;
      if (unlocked)   unl_seen++;
      if (error)      err_seen++;
      if (locked_out) lock_seen++;
   end

   function automatic logic [22:0] exp_vec();
      logic [15:0] dg = '0;
      foreach (m_q[i]) dg = {dg[11:0], 4'(m_q[i])};
      return {dg, 3'(m_q.size()), m_kv, m_mode == M_UNL, m_mode == M_ERR, m_mode == M_LOCK};
   endfunction

   // Drive one cycle, advance the model across the edge, return 1ns after it.
   task automatic cyc(input bit v, input logic [3:0] k, input bit rst);
      bit acc;
      int val;
      dav   = v;
      d     = v ? k : 4'($urandom);
      reset = rst;
      @(posedge clk);
      acc = 1'b0;
      if (rst) begin
         hi_run = 0; lo_run = 0; rearmed = 1'b0;
         m_q.delete(); m_fails = 0; m_mode = M_ENTRY; m_left = 0; m_kv = 1'b0;
      end else begin
         if (v) begin
            hi_run++; lo_run = 0;
            if (rearmed && hi_run == int'(DEB)) begin acc = 1'b1; rearmed = 1'b0; end
         end else begin
            lo_run++; hi_run = 0;
            if (lo_run >= int'(DEB)) rearmed = 1'b1;
         end
         m_kv = acc;
         if (m_mode != M_ENTRY) begin
            m_left--;
            if (m_left == 0) begin
               if (m_mode == M_LOCK) m_fails = 0;
               m_mode = M_ENTRY;
            end
         end else if (acc) begin
            if (k <= 4'd9) begin
               if (m_q.size() < 4) m_q.push_back(int'(k));
            end else if (k == KEY_F) begin
               val = 0;
               foreach (m_q[i]) val = val * 16 + m_q[i];
               if (m_q.size() == 4 && val == int'(CODE_P)) begin
                  m_mode = M_UNL; m_left = int'(HOLD); m_fails = 0;
               end else begin
                  m_fails++;
                  if (m_fails == MAXF) begin m_mode = M_LOCK; m_left = int'(LOCK); end
                  else begin m_mode = M_ERR; m_left = int'(HOLD); end
               end
               m_q.delete();
            end
         end
      end
      #1;
   endtask

   task automatic press(input logic [3:0] k, input int hold, input int rel);
      repeat (hold) cyc(1'b1, k, 1'b0);
      repeat (rel) cyc(1'b0, 4'h0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (3) cyc(1'b0, 4'h0, 1'b1);
      checks++;
      if (obs !== 23'h0) begin errors++; $display("FAIL reset_state got=%h want=%h", obs, 23'h0); end
      idle(6);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle got=%h want=%h", obs, exp_vec()); end
   endtask

   task automatic test_unlock();
      int u0;
      press(4'h1, 6, 6); press(4'h2, 6, 6); press(4'h3, 6, 6); press(4'h4, 6, 6);
      checks++;
      if (digits !== 16'h1234 || count !== 3'd4) begin
         errors++; $display("FAIL unlock_buffer got=%h/%0d want=1234/4", digits, count);
      end
      u0 = unl_seen;
      press(KEY_F, 6, 6);
      idle(4);
      checks++;
      if (unl_seen - u0 != 8) begin errors++; $display("FAIL unlock_dwell got=%0d want=8", unl_seen - u0); end
      checks++;
      if ({digits, count, unlocked} !== 20'h0) begin
         errors++; $display("FAIL unlock_exit got=%h/%0d/%b want=0/0/0", digits, count, unlocked);
      end
   endtask

   task automatic test_glitch();
      int k0;
      k0 = kv_seen;
      repeat (3) cyc(1'b1, 4'hA, 1'b0);
      repeat (2) cyc(1'b0, 4'h0, 1'b0);
      repeat (3) cyc(1'b1, 4'hA, 1'b0);
      repeat (2) cyc(1'b0, 4'h0, 1'b0);
      checks++;
      if (kv_seen != k0) begin errors++; $display("FAIL glitch_reject got=%0d want=0", kv_seen - k0); end
      press(4'hA, 5, 6);
      checks++;
      if (kv_seen - k0 != 1) begin errors++; $display("FAIL glitch_accept got=%0d want=1", kv_seen - k0); end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL glitch_state got=%h want=%h", obs, exp_vec()); end
   endtask

   task automatic test_lockout();
      int e0, l0, k0;
      for (int f = 0; f < 2; f++) begin
         e0 = err_seen;
         press(4'h1, 6, 6); press(4'h2, 6, 6); press(4'h3, 6, 6); press(4'h5, 6, 6);
         press(KEY_F, 6, 6);
         idle(4);
         checks++;
         if (err_seen - e0 != 8) begin errors++; $display("FAIL error_dwell f=%0d got=%0d want=8", f, err_seen - e0); end
      end
      l0 = lock_seen;
      press(4'h1, 6, 6); press(4'h2, 6, 6); press(4'h3, 6, 6); press(4'h5, 6, 6);
      press(KEY_F, 6, 0);
      checks++;
      if (locked_out !== 1'b1 || error !== 1'b0) begin
         errors++; $display("FAIL lockout_enter got=%b%b want=10", locked_out, error);
      end
      idle(6);
      k0 = kv_seen;
      press(4'h1, 5, 5);
      checks++;
      if (kv_seen - k0 != 1 || count !== 3'd0) begin
         errors++; $display("FAIL lockout_ignore got=kv%0d/cnt%0d want=kv1/cnt0", kv_seen - k0, count);
      end
      idle(6);
      checks++;
      if (lock_seen - l0 != 16) begin errors++; $display("FAIL lockout_dwell got=%0d want=16", lock_seen - l0); end
      // A single failure now must give ERROR, proving the fail counter restarted.
      press(4'h1, 6, 6); press(4'h2, 6, 6); press(4'h3, 6, 6); press(4'h5, 6, 6);
      press(KEY_F, 5, 0);
      checks++;
      if (error !== 1'b1 || locked_out !== 1'b0) begin
         errors++; $display("FAIL fails_cleared got=%b%b want=10", error, locked_out);
      end
      idle(12);
   endtask

   task automatic test_overflow();
      press(4'h9, 6, 6); press(4'h8, 6, 6); press(4'h7, 6, 6); press(4'h6, 6, 6); press(4'h5, 6, 6);
      checks++;
      if (digits !== 16'h9876 || count !== 3'd4) begin
         errors++; $display("FAIL overflow_buffer got=%h/%0d want=9876/4", digits, count);
      end
      press(KEY_F, 5, 0);
      checks++;
      if (error !== 1'b1 || digits !== 16'h0) begin
         errors++; $display("FAIL overflow_enter got=%b/%h want=1/0000", error, digits);
      end
      idle(12);
   endtask

   task automatic test_reset_mid();
      int k0;
      press(4'h1, 6, 6); press(4'h2, 6, 6);
      checks++;
      if (count !== 3'd2) begin errors++; $display("FAIL midreset_pre got=%0d want=2", count); end
      repeat (2) cyc(1'b1, 4'h3, 1'b0);
      cyc(1'b1, 4'h3, 1'b1);
      checks++;
      if (obs !== 23'h0) begin errors++; $display("FAIL midreset_entry got=%h want=%h", obs, 23'h0); end
      k0 = kv_seen;
      repeat (8) cyc(1'b1, 4'h3, 1'b0);
      idle(6);
      checks++;
      if (kv_seen != k0 || count !== 3'd0) begin
         errors++; $display("FAIL held_through_reset got=kv%0d/cnt%0d want=kv0/cnt0", kv_seen - k0, count);
      end
      press(4'h3, 6, 6);
      checks++;
      if (digits !== 16'h0003 || count !== 3'd1) begin
         errors++; $display("FAIL rearm_after_reset got=%h/%0d want=0003/1", digits, count);
      end
      cyc(1'b0, 4'h0, 1'b1);
      idle(6);
      press(4'h1, 6, 6); press(4'h2, 6, 6); press(4'h3, 6, 6); press(4'h4, 6, 6);
      press(KEY_F, 6, 0);
      checks++;
      if (unlocked !== 1'b1) begin errors++; $display("FAIL midreset_unlock got=%b want=1", unlocked); end
      cyc(1'b0, 4'h0, 1'b1);
      checks++;
      if (obs !== 23'h0) begin errors++; $display("FAIL midreset_dwell got=%h want=%h", obs, 23'h0); end
      idle(6);
   endtask

   task automatic test_random();
      int idx = 0;
      logic [15:0] cv = CODE_P;
      logic [3:0] k;
      int hold, rel, r;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin k = KEY_F; idx = 0; end
         else if (r == 2) k = 4'($urandom);
         else begin k = cv[15 - 4*idx -: 4]; idx = (idx + 1) % 4; end
         hold = $urandom_range(1, 7);
         rel  = $urandom_range(1, 7);
         for (int i = 0; i < hold + rel; i++) begin
            cyc(i < hold, k, $urandom_range(0, 299) == 0);
            checks++;
            if (obs !== exp_vec()) begin
               errors++; $display("FAIL random n=%0d i=%0d got=%h want=%h", n, i, obs, exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unlock();
      test_glitch();
      test_lockout();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
